// File: rtl/and_primitive_pkg.sv
// Shared constants and helpers for the AND primitive cell family.
package and_primitive_pkg;

  localparam int AND_PRIM_MAX_WIDTH = 64;
  localparam int STAT_W             = 16;

  // Counts set bits of a zero-extended operand; result fits 0..64.
  function automatic logic [6:0] popcount_f(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < AND_PRIM_MAX_WIDTH; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/and_popcount.sv
// Combinational ones-counter for a WIDTH-bit vector.
module and_popcount
  import and_primitive_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_v,
  output logic [CNT_W-1:0] o_cnt
);

  logic [AND_PRIM_MAX_WIDTH-1:0] w_ext;

  always_comb begin
    w_ext             = '0;
    w_ext[WIDTH-1:0]  = i_v;
    o_cnt             = CNT_W'(popcount_f(w_ext));
  end

endmodule

// File: rtl/and_primitive_cell.sv
// Bitwise AND leaf cell with a registered, valid-qualified result and reduction flags.
// Define AND_PRIMITIVE_STATS_EN to add saturating transaction / all-ones counters.
module and_primitive_cell
  import and_primitive_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  y,
  output logic [WIDTH-1:0]  y_q,
  output logic              out_valid,
  output logic              all_q,
  output logic              any_q,
  output logic [CNT_W-1:0]  ones_q
`ifdef AND_PRIMITIVE_STATS_EN
  ,
  output logic [STAT_W-1:0] txn_cnt,
  output logic [STAT_W-1:0] full_cnt
`endif
);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] w_y;
  logic             w_all;
  logic             w_any;
  logic [CNT_W-1:0] w_ones;

  assign w_y   = a & b;
  assign w_all = &w_y;
  assign w_any = |w_y;
  assign y     = w_y;

  and_popcount #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_popcount (
    .i_v   (w_y),
    .o_cnt (w_ones)
  );

  // Stage p1: registered result; data holds when no new input is accepted.
  logic [WIDTH-1:0] r_y_p1;
  logic             r_all_p1;
  logic             r_any_p1;
  logic [CNT_W-1:0] r_ones_p1;
  logic             r_vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_p1    <= '0;
      r_all_p1  <= 1'b0;
      r_any_p1  <= 1'b0;
      r_ones_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_y_p1    <= w_y;
        r_all_p1  <= w_all;
        r_any_p1  <= w_any;
        r_ones_p1 <= w_ones;
      end
    end
  end

  assign y_q       = r_y_p1;
  assign all_q     = r_all_p1;
  assign any_q     = r_any_p1;
  assign ones_q    = r_ones_p1;
  assign out_valid = r_vld_p1;

`ifdef AND_PRIMITIVE_STATS_EN
  logic [STAT_W-1:0] r_txn_p1;
  logic [STAT_W-1:0] r_full_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txn_p1  <= '0;
      r_full_p1 <= '0;
    end else if (in_valid) begin
      r_txn_p1 <= sat_inc(r_txn_p1);
      if (w_all) begin
        r_full_p1 <= sat_inc(r_full_p1);
      end
    end
  end

  assign txn_cnt  = r_txn_p1;
  assign full_cnt = r_full_p1;
`endif

endmodule

// File: tb/tb_and_primitive_cell.sv
// Bench for and_primitive_cell: table vectors, WIDTH=1 corner cases and random model check.
module tb_and_primitive_cell;
  import and_primitive_pkg::*;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  logic       rst, vld;
  logic [7:0] a8, b8, y8, yq8;
  logic       ov8, all8, any8;
  logic [3:0] ones8;
  logic [0:0] a1, b1, y1, yq1, ones1;
  logic       ov1, all1, any1;
`ifdef AND_PRIMITIVE_STATS_EN
  logic [STAT_W-1:0] txn8, full8, txn1, full1;
`endif

  and_primitive_cell #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(vld), .a(a8), .b(b8), .y(y8), .y_q(yq8),
    .out_valid(ov8), .all_q(all8), .any_q(any8), .ones_q(ones8)
`ifdef AND_PRIMITIVE_STATS_EN
    , .txn_cnt(txn8), .full_cnt(full8)
`endif
  );

  and_primitive_cell #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vld), .a(a1), .b(b1), .y(y1), .y_q(yq1),
    .out_valid(ov1), .all_q(all1), .any_q(any1), .ones_q(ones1)
`ifdef AND_PRIMITIVE_STATS_EN
    , .txn_cnt(txn1), .full_cnt(full1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, vld;
    logic [7:0] a, b;
    logic [7:0] y_q;
    logic       all_q, any_q;
    logic [3:0] ones_q;
    logic       ov;
  } vec_t;

  vec_t vt[11];

  // Reference state for the random phase.
  logic [7:0] m_y;
  logic       m_ov;
  logic [7:0] m_and;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 4'd0, 0};
    vt[1]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 4'd0, 0};
    vt[2]  = '{0, 1, 8'hF0, 8'h3C, 8'h30, 0, 1, 4'd2, 1};
    vt[3]  = '{0, 1, 8'hFF, 8'hFF, 8'hFF, 1, 1, 4'd8, 1};
    vt[4]  = '{0, 0, 8'h00, 8'hFF, 8'hFF, 1, 1, 4'd8, 0};
    vt[5]  = '{1, 1, 8'hAA, 8'hAA, 8'h00, 0, 0, 4'd0, 0};
    vt[6]  = '{0, 1, 8'hAA, 8'hAA, 8'hAA, 0, 1, 4'd4, 1};
    vt[7]  = '{0, 1, 8'hFF, 8'h0F, 8'h0F, 0, 1, 4'd4, 1};
    vt[8]  = '{0, 1, 8'h00, 8'hFF, 8'h00, 0, 0, 4'd0, 1};
    vt[9]  = '{0, 1, 8'hFF, 8'hFF, 8'hFF, 1, 1, 4'd8, 1};
    vt[10] = '{0, 0, 8'h12, 8'h34, 8'hFF, 1, 1, 4'd8, 0};

    rst = 1'b0; vld = 1'b0; a8 = '0; b8 = '0; a1 = '0; b1 = '0;

    // WIDTH=1 combinational path with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #1;
      check("comb_w1_y", 64'(y1), 64'(ab == 2'b11));
      #19;
    end
    a8 = 8'hC3; b8 = 8'h5A;
    #1;
    check("comb_w8_y", 64'(y8), 64'h42);

    clk_en = 1'b1;
    #1;

    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst; vld = vt[i].vld; a8 = vt[i].a; b8 = vt[i].b;
      tick();
      check($sformatf("vec%0d_y_q", i),   64'(yq8),   64'(vt[i].y_q));
      check($sformatf("vec%0d_all_q", i), 64'(all8),  64'(vt[i].all_q));
      check($sformatf("vec%0d_any_q", i), 64'(any8),  64'(vt[i].any_q));
      check($sformatf("vec%0d_ones_q", i), 64'(ones8), 64'(vt[i].ones_q));
      check($sformatf("vec%0d_out_valid", i), 64'(ov8), 64'(vt[i].ov));
    end

    // WIDTH=1 registered path: all_q/any_q/ones_q track y_q.
    rst = 1'b1; vld = 1'b0; tick();
    rst = 1'b0; vld = 1'b1; a1 = 1'b1; b1 = 1'b1; tick();
    check("w1_y_q_one", 64'(yq1), 64'h1);
    check("w1_all_one", 64'(all1), 64'h1);
    check("w1_any_one", 64'(any1), 64'h1);
    check("w1_ones_one", 64'(ones1), 64'h1);
    check("w1_ov_one", 64'(ov1), 64'h1);
    a1 = 1'b1; b1 = 1'b0; tick();
    check("w1_y_q_zero", 64'(yq1), 64'h0);
    check("w1_all_zero", 64'(all1), 64'h0);
    check("w1_any_zero", 64'(any1), 64'h0);
    check("w1_ones_zero", 64'(ones1), 64'h0);

`ifdef AND_PRIMITIVE_STATS_EN
    rst = 1'b1; vld = 1'b0; tick();
    check("stats_txn_rst", 64'(txn8), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vld = 1'b1;
      a8 = (i == 1 || i == 3) ? 8'hFF : 8'h7E;
      b8 = 8'hFF;
      tick();
    end
    vld = 1'b0; tick();
    check("stats_txn", 64'(txn8), 64'd5);
    check("stats_full", 64'(full8), 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("stats_txn_clr", 64'(txn8), 64'h0);
    check("stats_full_clr", 64'(full8), 64'h0);
`endif

    // Random phase against a behavioural model.
    rst = 1'b1; vld = 1'b0; tick();
    m_y = 8'h00; m_ov = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(15) == 0);
      vld = $urandom_range(1);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      #1;
      m_and = a8 & b8;
      check("rnd_y", 64'(y8), 64'(m_and));
      if (rst) begin
        m_y = 8'h00; m_ov = 1'b0;
      end else if (vld) begin
        m_y = m_and; m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
      tick();
      check("rnd_y_q", 64'(yq8), 64'(m_y));
      check("rnd_ov", 64'(ov8), 64'(m_ov));
      check("rnd_ones", 64'(ones8), 64'($countones(m_y)));
      check("rnd_all", 64'(all8), 64'(!rst && m_y == 8'hFF));
      check("rnd_any", 64'(any8), 64'(m_y != 8'h00));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/and_primitive_cell.md
Name: and_primitive_cell

Overview:
Parameterised bitwise two-input AND primitive.
- Combinational output `y` = `a & b`, available with no clock activity.
- Registered, valid-qualified copy of the result, plus reduction flags and a ones-count of the registered result.
- Used as a leaf cell wherever gated or masked bit vectors are needed, e.g. enable masking and match detection.

Parameters:
- WIDTH, 1, bit width of `a`, `b`, `y`, `y_q`; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), width of `ones_q`; derived, not overridden by users.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  qualifies `a`/`b` for the registered path
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- y  out  WIDTH  combinational `a & b`
- y_q  out  WIDTH  registered `a & b`
- out_valid  out  1  `y_q`, `all_q`, `any_q`, `ones_q` hold a new result this cycle
- all_q  out  1  registered reduction-AND of `a & b`
- any_q  out  1  registered reduction-OR of `a & b`
- ones_q  out  CNT_W  registered count of 1-bits in `a & b`

Behaviour:
- Combinational path:
  - `y` = `a & b` bitwise at all times, independent of `clk`, `rst` and `in_valid`.
  - Settles within the same delta, no latency.
  - Must work with `clk` held constant.
- Registered path, 1-cycle latency. On each rising edge:
  - If `rst`=1: `y_q`=0, `all_q`=0, `any_q`=0, `ones_q`=0, `out_valid`=0.
  - Else if `in_valid`=1: `y_q` ← `a & b`; `all_q` ← &(`a & b`); `any_q` ← |(`a & b`); `ones_q` ← popcount(`a & b`); `out_valid` ← 1.
  - Else: `y_q`, `all_q`, `any_q`, `ones_q` hold their previous values; `out_valid` ← 0.
- `out_valid` is a one-cycle pulse per accepted input. Back-to-back `in_valid` gives `out_valid` high continuously.
- No backpressure; every `in_valid` cycle is accepted.
- Reset mid-stream: a result presented on the reset edge is discarded. `out_valid` is 0 on the cycle after reset.
- `rst` and `in_valid` high together: reset wins.
- X/Z on `a`/`b` propagates to `y` per standard Verilog AND semantics (0 & X = 0). Registered outputs use the same operator.
- WIDTH=1: `all_q` = `any_q` = `y_q`; `ones_q` is 1 bit.

Optional Feature:
Macro `AND_PRIMITIVE_STATS_EN`.
- Defined:
  - Adds outputs `txn_cnt` [15:0], counting accepted `in_valid` cycles.
  - Adds outputs `full_cnt` [15:0], counting accepted cycles where &(`a & b`)=1.
  - Both counters are saturating at 16'hFFFF, cleared by `rst`, and update on the same edge as `y_q`.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `and_primitive_pkg`:
  - localparam `AND_PRIM_MAX_WIDTH`=64.
  - function `popcount_f(input [63:0] v)` returning the count.
  - `STAT_W`=16.
- One natural sub-module: `and_popcount`, a combinational ones-counter of the WIDTH-bit `a & b`, instantiated once.
- The top holds the AND, reduction logic, registers and optional counters.

Test Plan:
1. WIDTH=1, `clk` idle, `rst`=0: drive `a`/`b` = 00, 01, 10, 11 at 20 ns steps → `y` = 0, 0, 0, 1, each settled within the step, no clock needed.
2. WIDTH=8, `rst` high for 2 edges → all registered outputs 0 and `out_valid`=0. Release `rst`; `in_valid`=1, `a`=8'hF0, `b`=8'h3C → next edge: `y_q`=8'h30, `any_q`=1, `all_q`=0, `ones_q`=2, `out_valid`=1.
3. WIDTH=8, `a`=`b`=8'hFF with `in_valid`=1, then `in_valid`=0 with `a`=8'h00 → after first edge `all_q`=1, `ones_q`=8; after second edge `out_valid`=0 and `y_q` holds 8'hFF.
4. WIDTH=8, `in_valid`=1 and `rst`=1 on the same edge with `a`=`b`=8'hAA → `y_q`=0, `out_valid`=0. The following edge with `rst`=0 gives `y_q`=8'hAA, `ones_q`=4.
5. WIDTH=8, 3 back-to-back valids: (FF,0F), (00,FF), (FF,FF) → `out_valid` high 3 consecutive cycles; `y_q` = 0F, 00, FF; `any_q` = 1, 0, 1.
6. `AND_PRIMITIVE_STATS_EN` defined, WIDTH=4: 5 valids, of which 2 have `a`=`b`=4'hF → `txn_cnt`=5, `full_cnt`=2; pulse `rst` → both 0.
